ttl191_sequencer: RTL and testbench
===================================

TTL191_SEQUENCER -- requirements
Module: ttl191_sequencer

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 2, number of cycles LOAD_n is held low per load (legal 1..15).
REQ-002 SHALL have ports as below, one clock (CLK), reset synchronous active-high (RESET):
- CLK  input  1  rising-edge clock, shared with the driven counter
- RESET  input  1  synchronous, active-high reset
- CMD_VALID  input  1  command offered
- CMD_READY  output  1  sequencer can accept a command
- CMD_OP  input  2  00=LOAD, 01=COUNT UP, 10=COUNT DOWN, 11=NOP
- CMD_DATA  input  4  load value (LOAD) or step count N (COUNT)
- Q  input  4  counter output fed back from the 74LS191
- D  output  4  parallel data to counter
- LOAD_n  output  1  counter load, active low
- CTEN_n  output  1  counter count enable, active low
- DOWN_UP_n  output  1  counter direction, 0=up, 1=down
- DONE  output  1  one-cycle completion pulse
- RESULT  output  4  Q captured at completion
- WRAP  output  1  count passed terminal value during last command
- MISMATCH  output  1  final Q differs from expected (see REQ-020)

Function
REQ-003 SHALL implement states IDLE, LOAD, COUNT, SETTLE, FIN; CMD_READY=1 only in IDLE with RESET low.
REQ-004 SHALL accept a command on a rising edge where CMD_VALID=1 and CMD_READY=1; CMD_VALID in any other state SHALL be ignored, not queued.
REQ-005 On accept SHALL register CMD_OP, CMD_DATA and start value Q, clear WRAP and MISMATCH.
REQ-006 LOAD: D=CMD_DATA from the accept edge; LOAD_n low for exactly LOAD_CYCLES cycles starting the cycle after accept, then SETTLE.
REQ-007 COUNT UP/DOWN with N>0: DOWN_UP_n updated on the accept edge; CTEN_n low for exactly N consecutive cycles starting the cycle after accept, then SETTLE.
REQ-008 COUNT with N=0 and NOP: no counter pin changes except DOWN_UP_n for COUNT; go directly to SETTLE.
REQ-009 SETTLE: one cycle, all control pins inactive (LOAD_n=1, CTEN_n=1); RESULT<=Q at its end.
REQ-010 FIN: DONE=1 for exactly one cycle, CMD_READY=0; next state IDLE.
REQ-011 Latency accept-edge to DONE high: LOAD_CYCLES+2 for LOAD, N+2 for COUNT, 2 for N=0/NOP.
REQ-012 WRAP SHALL set when, in a COUNT cycle with CTEN_n=0, Q=1111 (up) or Q=0000 (down); held until next accept.
REQ-013 D, DOWN_UP_n and RESULT SHALL hold their last values between commands.
REQ-014 LOAD_n and CTEN_n SHALL never be low in the same cycle.

Reset
REQ-015 RESET high on an edge SHALL force: IDLE, D=0000, LOAD_n=1, CTEN_n=1, DOWN_UP_n=0, DONE=0, RESULT=0000, WRAP=0, MISMATCH=0.
REQ-016 CMD_READY SHALL be 0 while RESET is high and 1 the cycle after RESET falls.
REQ-017 RESET mid-operation SHALL abort: control pins inactive from that edge, no DONE for the aborted command.

Configuration
REQ-018 Macro TTL191_SEQUENCER_VERIFY_EN SHALL compile in the final-value checker.
REQ-019 Without the macro: MISMATCH tied 0, no expected-value logic.
REQ-020 With the macro: expected = CMD_DATA for LOAD, start Q +/- N modulo 16 for COUNT, start Q for NOP; MISMATCH<=(RESULT!=expected) on the SETTLE edge, valid with DONE, held until next accept.

Verification
REQ-021 Reset, LOAD 0101 -> LOAD_n low 2 cycles, D=0101, DONE 4 cycles after accept, RESULT=0101.
REQ-022 From 0101, UP N=5 -> DOWN_UP_n=0, CTEN_n low exactly 5 cycles, RESULT=1010, WRAP=0.
REQ-023 LOAD 1101 then UP N=4 -> RESULT=0001, WRAP=1; LOAD 0010 then DOWN N=3 -> DOWN_UP_n=1, RESULT=1111, WRAP=1.
REQ-024 UP N=0 -> CTEN_n never low, DONE 2 cycles after accept, RESULT=unchanged Q; CMD_VALID held during busy accepted only after FIN.
REQ-025 RESET after 2 of 6 count cycles -> CTEN_n=1 on that edge, no DONE, CMD_READY=1 cycle after RESET falls.
REQ-026 With TTL191_SEQUENCER_VERIFY_EN, counter model drops one count of UP N=3 from 1000 -> RESULT=1010, MISMATCH=1; normal run -> MISMATCH=0.

Source files
------------

// File: rtl/ttl191_sequencer.sv
// ttl191_sequencer: command-driven sequencer for an external 74LS191 up/down
// counter. Accepts LOAD / COUNT UP / COUNT DOWN / NOP commands, drives the
// counter's LOAD_n, CTEN_n, DOWN_UP_n and D pins, then captures Q as RESULT
// and pulses DONE.
//
// Optional feature: define TTL191_SEQUENCER_VERIFY_EN to build the
// final-value checker that drives MISMATCH. Without it, MISMATCH is tied low
// and no expected-value logic is built.
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1. CMD_READY is 1 only in IDLE with RESET low, and
// CMD_VALID seen in any other state is dropped rather than queued.
module ttl191_sequencer #(
  parameter int LOAD_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [3:0] CMD_DATA,
  input  logic [3:0] Q,
  output logic [3:0] D,
  output logic       LOAD_n,
  output logic       CTEN_n,
  output logic       DOWN_UP_n,
  output logic       DONE,
  output logic [3:0] RESULT,
  output logic       WRAP,
  output logic       MISMATCH
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COUNT  = 3'd2,
    S_SETTLE = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // The cycle counter counts down to zero, so LOAD_n stays low LOAD_CYCLES cycles.
  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic       load_n_q, load_n_d;
  logic       cten_n_q, cten_n_d;
  logic       down_up_n_q, down_up_n_d;
  logic [3:0] result_q, result_d;
  logic       wrap_q, wrap_d;
  logic       accept;
  logic       at_terminal;

`ifdef TTL191_SEQUENCER_VERIFY_EN
  logic [1:0] op_q, op_d;
  logic [3:0] data_q, data_d;
  logic [3:0] start_q, start_d;
  logic       mismatch_q, mismatch_d;
  logic [3:0] exp_val;
`endif

  assign CMD_READY = (state_q == S_IDLE) && !RESET;
  assign accept    = CMD_VALID && CMD_READY;

  // The counter is about to roll over when it sits at its terminal value
  // for the current direction while counting is enabled.
  assign at_terminal = down_up_n_q ? (Q == 4'h0) : (Q == 4'hF);

`ifdef TTL191_SEQUENCER_VERIFY_EN
  // Value the counter should hold after the command, modulo 16.
  always_comb begin
    exp_val = start_q;
    case (op_q)
      OP_LOAD: exp_val = data_q;
      OP_UP:   exp_val = start_q + data_q;
      OP_DOWN: exp_val = start_q - data_q;
      default: exp_val = start_q;
    endcase
  end
`endif

  // Next-state and next-pin logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    load_n_d    = load_n_q;
    cten_n_d    = cten_n_q;
    down_up_n_d = down_up_n_q;
    result_d    = result_q;
    wrap_d      = wrap_q;
`ifdef TTL191_SEQUENCER_VERIFY_EN
    op_d        = op_q;
    data_d      = data_q;
    start_d     = start_q;
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wrap_d = 1'b0;
`ifdef TTL191_SEQUENCER_VERIFY_EN
          op_d       = CMD_OP;
          data_d     = CMD_DATA;
          start_d    = Q;
          mismatch_d = 1'b0;
`endif
          case (CMD_OP)
            OP_LOAD: begin
              d_d      = CMD_DATA;
              load_n_d = 1'b0;
              cnt_d    = LOAD_LAST;
              state_d  = S_LOAD;
            end
            OP_UP, OP_DOWN: begin
              down_up_n_d = (CMD_OP == OP_DOWN);
              if (CMD_DATA != 4'd0) begin
                cten_n_d = 1'b0;
                cnt_d    = CMD_DATA - 4'd1;
                state_d  = S_COUNT;
              end else begin
                state_d = S_SETTLE;
              end
            end
            default: state_d = S_SETTLE;
          endcase
        end
      end
      S_LOAD: begin
        if (cnt_q == 4'd0) begin
          load_n_d = 1'b1;
          state_d  = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_COUNT: begin
        if (at_terminal) begin
          wrap_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          cten_n_d = 1'b1;
          state_d  = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETTLE: begin
        result_d = Q;
`ifdef TTL191_SEQUENCER_VERIFY_EN
        mismatch_d = (Q != exp_val);
`endif
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        load_n_d = 1'b1;
        cten_n_d = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and pin registers; reset puts every pin in its inactive value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      d_q         <= 4'd0;
      load_n_q    <= 1'b1;
      cten_n_q    <= 1'b1;
      down_up_n_q <= 1'b0;
      result_q    <= 4'd0;
      wrap_q      <= 1'b0;
`ifdef TTL191_SEQUENCER_VERIFY_EN
      op_q        <= OP_NOP;
      data_q      <= 4'd0;
      start_q     <= 4'd0;
      mismatch_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      load_n_q    <= load_n_d;
      cten_n_q    <= cten_n_d;
      down_up_n_q <= down_up_n_d;
      result_q    <= result_d;
      wrap_q      <= wrap_d;
`ifdef TTL191_SEQUENCER_VERIFY_EN
      op_q        <= op_d;
      data_q      <= data_d;
      start_q     <= start_d;
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign D         = d_q;
  assign LOAD_n    = load_n_q;
  assign CTEN_n    = cten_n_q;
  assign DOWN_UP_n = down_up_n_q;
  assign DONE      = (state_q == S_FIN);
  assign RESULT    = result_q;
  assign WRAP      = wrap_q;

`ifdef TTL191_SEQUENCER_VERIFY_EN
  assign MISMATCH = mismatch_q;
`else
  assign MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_ttl191_sequencer.sv
// tb_ttl191_sequencer: drives ttl191_sequencer against a behavioural 74LS191
// model; expected results come from plain modular arithmetic on the command.
`timescale 1ns/1ps
module tb_ttl191_sequencer;

  localparam int LOAD_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b11;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_ready;
  logic [3:0] q;
  logic [3:0] d;
  logic       load_n, cten_n, down_up_n, done, wrap, mismatch;
  logic [3:0] result;

  always #5 clk = ~clk;

  ttl191_sequencer #(.LOAD_CYCLES(LOAD_CYCLES)) dut (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_OP(cmd_op), .CMD_DATA(cmd_data), .Q(q), .D(d), .LOAD_n(load_n),
    .CTEN_n(cten_n), .DOWN_UP_n(down_up_n), .DONE(done), .RESULT(result),
    .WRAP(wrap), .MISMATCH(mismatch)
  );

  // ---------------- 74LS191 model (synchronous load) ----------------
  logic [3:0] q_model = 4'd5;
  logic       drop_req = 1'b0;
  logic       drop_done = 1'b0;

  always @(posedge clk) begin
    if (!load_n) q_model <= d;
    else if (!cten_n) begin
      if (drop_req && !drop_done) drop_done <= 1'b1;
      else q_model <= down_up_n ? q_model - 4'd1 : q_model + 4'd1;
    end
  end
  assign q = q_model;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] lat;
    logic [3:0]  result;
    logic        wrap;
    logic        mism;
    logic [3:0]  d;
    logic        dir;
    logic [7:0]  l_cnt;
    logic [7:0]  c_cnt;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int fails = 0;
  int acc_gen = 0;
  int rst_gen = 0;
  logic [3:0] d_m = 4'd0;
  logic       dir_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   acc_seen = 0;
  int   rst_seen = 0;
  bit   active = 0;
  int   k = 0;
  int   l_cnt, l_first, l_last, c_cnt, c_first, c_last;
  bit   both_low;
  exp_t me;

  // Track pin activity of the current command and score it on DONE.
  always @(negedge clk) begin
    if (rst_seen != rst_gen) begin
      rst_seen = rst_gen;
      active   = 0;
    end
    if (acc_seen != acc_gen) begin
      acc_seen = acc_gen;
      active = 1; k = 1;
      l_cnt = 0; l_first = 0; l_last = 0;
      c_cnt = 0; c_first = 0; c_last = 0;
      both_low = 0;
    end else if (active) begin
      k++;
    end
    if (active) begin
      if (!load_n) begin l_cnt++; if (l_first == 0) l_first = k; l_last = k; end
      if (!cten_n) begin c_cnt++; if (c_first == 0) c_first = k; c_last = k; end
      if (!load_n && !cten_n) both_low = 1;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0 || !active) begin
        vectors++; fails++;
        $display("FAIL unexpected_done: got DONE=1 expected no DONE at %0t", $time);
      end else begin
        me = exp_t'(exp_q.pop_front());
        check("latency", k, me.lat);
        check("result", result, me.result);
        check("wrap", wrap, me.wrap);
        check("mismatch", mismatch, me.mism);
        check("d_hold", d, me.d);
        check("dir_hold", down_up_n, me.dir);
        check("load_n_cycles", l_cnt, me.l_cnt);
        check("load_n_window", (l_cnt == 0) || (l_first == 1 && l_last == l_cnt), 1);
        check("cten_n_cycles", c_cnt, me.c_cnt);
        check("cten_n_window", (c_cnt == 0) || (c_first == 1 && c_last == c_cnt), 1);
        check("pins_exclusive", both_low, 0);
        check("ready_in_fin", cmd_ready, 0);
      end
      active = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [3:0] data,
                       input bit push_it, input bit drop);
    exp_t e;
    int   n;
    int   t;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      vectors++; fails++;
      $display("FAIL accept_timeout: got no CMD_READY expected ready within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    n = int'(data);
    e = '0;
    case (op)
      2'b00: begin
        e.result = data; e.lat = LOAD_CYCLES + 2; e.l_cnt = 8'(LOAD_CYCLES);
        d_m = data;
      end
      2'b01: begin
        e.result = 4'((int'(q_model) + n) % 16); e.wrap = (int'(q_model) + n) > 15;
        e.lat = n + 2; e.c_cnt = 8'(n); dir_m = 1'b0;
      end
      2'b10: begin
        e.result = 4'((int'(q_model) - n + 16) % 16); e.wrap = n > int'(q_model);
        e.lat = n + 2; e.c_cnt = 8'(n); dir_m = 1'b1;
      end
      default: begin
        e.result = q_model; e.lat = 2;
      end
    endcase
    if (drop) begin
      // The counter model swallows one count: the captured value falls one short.
      e.result = e.result - 4'd1;
`ifdef TTL191_SEQUENCER_VERIFY_EN
      e.mism = 1'b1;
`endif
    end
    e.d = d_m;
    e.dir = dir_m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_data = 4'($urandom_range(0, 15));
    if (push_it) exp_q.push_back(W'(e));
    acc_gen++;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || active || acc_seen != acc_gen) && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      vectors++; fails++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    reset = 1'b1;
    cmd_valid = 1'b0;
    rst_gen++;
    d_m = 4'd0; dir_m = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_d", d, 0);
    check("rst_load_n", load_n, 1);
    check("rst_cten_n", cten_n, 1);
    check("rst_down_up_n", down_up_n, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_wrap", wrap, 0);
    check("rst_mismatch", mismatch, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(2);

    // Load, count up without wrap.
    issue(2'b00, 4'b0101, 1, 0); wait_idle();
    issue(2'b01, 4'd5, 1, 0);    wait_idle();
    // Wrapping counts in both directions.
    issue(2'b00, 4'b1101, 1, 0); wait_idle();
    issue(2'b01, 4'd4, 1, 0);    wait_idle();
    issue(2'b00, 4'b0010, 1, 0); wait_idle();
    issue(2'b10, 4'd3, 1, 0);    wait_idle();
    // Zero-length count; then back-to-back commands with CMD_VALID held while busy.
    issue(2'b01, 4'd0, 1, 0);
    issue(2'b00, 4'b0111, 1, 0);
    issue(2'b11, 4'd9, 1, 0);
    issue(2'b10, 4'd0, 1, 0);    wait_idle();

    // Abort a 6-step count after two count cycles.
    issue(2'b00, 4'd0, 1, 0);    wait_idle();
    issue(2'b01, 4'd6, 0, 0);
    @(negedge clk);
    do_reset(1);
    repeat (10) @(negedge clk);
    check("abort_q", q_model, 2);

    // Randomized commands with random gaps.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

`ifdef TTL191_SEQUENCER_VERIFY_EN
    // Counter drops one count of UP 3 from 1000.
    issue(2'b00, 4'b1000, 1, 0); wait_idle();
    drop_req = 1'b1;
    issue(2'b01, 4'd3, 1, 1);    wait_idle();
    drop_req = 1'b0;
    issue(2'b01, 4'd1, 1, 0);    wait_idle();
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000ns");
    $fatal(1, "timeout");
  end

endmodule
